// File: rtl/pcg_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit PCG-style noise generator among NREQ
// requesters; every grant consumes exactly one generator step and returns one tagged word.
module pcg_share_arbiter #(
  parameter int          NREQ       = 4,
  parameter int          WARMUP     = 2,
  parameter logic [15:0] RESET_SEED = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_load,
  input  logic [15:0]             seed,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [7:0]              rnd,
  output logic [$clog2(NREQ)-1:0] rnd_id,
  output logic                    rnd_valid,
  output logic                    busy
);

  // Handshake: req is a level request sampled on every edge; a one-cycle gnt pulse
  // means that request was served, and rnd_valid qualifies rnd/rnd_id for exactly
  // one cycle, one cycle after the gnt pulse. There is no back-pressure.

  localparam int IDW = $clog2(NREQ);

  localparam logic [0:0] ST_WARM = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  // With no warm-up the generator is usable straight away, so skip WARM entirely.
  localparam logic [0:0] ST_INIT  = (WARMUP == 0) ? ST_RUN : ST_WARM;
  localparam logic [3:0] WARM_CNT = 4'(WARMUP);

  logic [0:0]     fsm;
  logic [15:0]    state;
  logic [15:0]    state_nx;
  logic [3:0]     cnt;
  logic [3:0]     cnt_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic [NREQ-1:0] gnt_nx;
  logic [7:0]     mix_x;
  logic [2:0]     mix_r;

  logic           s1_valid;
  logic [7:0]     s1_x;
  logic [2:0]     s1_r;
  logic [IDW-1:0] s1_id;
  logic [7:0]     rot;

  assign state_nx = state * 16'h5851 + 16'h1405;
  assign cnt_nx   = cnt + 4'd1;
  // (s ^ (s >> 1))[10:3] without building the unused upper/lower bits.
  assign mix_x    = state[10:3] ^ state[11:4];
  assign mix_r    = state[5:3];
  assign busy     = (fsm == ST_WARM);

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    gnt_nx         = '0;
    gnt_nx[winner] = 1'b1;
  end

  always_comb begin
    rot = s1_x;
    case (s1_r)
      3'd0:    rot = s1_x;
      3'd1:    rot = {s1_x[0],   s1_x[7:1]};
      3'd2:    rot = {s1_x[1:0], s1_x[7:2]};
      3'd3:    rot = {s1_x[2:0], s1_x[7:3]};
      3'd4:    rot = {s1_x[3:0], s1_x[7:4]};
      3'd5:    rot = {s1_x[4:0], s1_x[7:5]};
      3'd6:    rot = {s1_x[5:0], s1_x[7:6]};
      3'd7:    rot = {s1_x[6:0], s1_x[7]};
      default: rot = s1_x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= ST_INIT;
      state     <= RESET_SEED;
      cnt       <= '0;
      ptr       <= IDW'(NREQ - 1);
      gnt       <= '0;
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_r      <= '0;
      s1_id     <= '0;
      rnd       <= '0;
      rnd_id    <= '0;
      rnd_valid <= 1'b0;
    end else begin
      gnt      <= '0;
      s1_valid <= 1'b0;
      if (seed_load) begin
        state <= seed;
        cnt   <= '0;
        fsm   <= ST_INIT;
      end else if (fsm == ST_WARM) begin
        state <= state_nx;
        cnt   <= cnt_nx;
        if (cnt_nx == WARM_CNT) fsm <= ST_RUN;
      end else if (|req) begin
        gnt      <= gnt_nx;
        ptr      <= winner;
        state    <= state_nx;
        s1_valid <= 1'b1;
        s1_x     <= mix_x;
        s1_r     <= mix_r;
        s1_id    <= winner;
      end
      // Stage 2 drains regardless of seed_load so in-flight words keep their tag.
      rnd_valid <= s1_valid;
      if (s1_valid) begin
        rnd    <= rot;
        rnd_id <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_pcg_share_arbiter.sv
// Scoreboard bench for pcg_share_arbiter: a WARMUP=2 instance for the main
// scenarios and a WARMUP=0 instance for the no-warm-up and reseed cases.
module tb_pcg_share_arbiter;

  typedef struct packed {
    int         cyc;
    logic [3:0] g;
    logic [1:0] id;
    logic [7:0] w;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (WARMUP=2)
  logic        rst, seed_load, rnd_valid, busy;
  logic [15:0] seed;
  logic [3:0]  req, gnt;
  logic [7:0]  rnd;
  logic [1:0]  rnd_id;
  // second instance (WARMUP=0)
  logic        rst0, seed_load0, rnd_valid0, busy0;
  logic [15:0] seed0;
  logic [3:0]  req0, gnt0;
  logic [7:0]  rnd0;
  logic [1:0]  rnd_id0;

  pcg_share_arbiter #(.NREQ(4), .WARMUP(2), .RESET_SEED(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .gnt(gnt), .rnd(rnd), .rnd_id(rnd_id), .rnd_valid(rnd_valid), .busy(busy)
  );

  pcg_share_arbiter #(.NREQ(4), .WARMUP(0), .RESET_SEED(16'h0000)) u_w0 (
    .clk(clk), .rst(rst0), .seed_load(seed_load0), .seed(seed0), .req(req0),
    .gnt(gnt0), .rnd(rnd0), .rnd_id(rnd_id0), .rnd_valid(rnd_valid0), .busy(busy0)
  );

  ent_t gnt_q[$];
  ent_t exp_q[$];
  ent_t w0_gnt_q[$];
  ent_t w0_exp_q[$];
  ent_t me, me0;
  logic [7:0]  last_w, last_w0;
  logic [15:0] m_state;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pcg_step(input logic [15:0] s);
    return s * 16'h5851 + 16'h1405;
  endfunction

  function automatic logic [7:0] pcg_word(input logic [15:0] s);
    logic [15:0] m;
    logic [7:0]  x;
    int          r;
    m = s ^ (s >> 1);
    x = m[10:3];
    r = int'(s[5:3]);
    for (int i = 0; i < r; i++) x = {x[0], x[7:1]};
    return x;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst) begin
      last_w = 8'h00;
    end else begin
      if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
        me = gnt_q.pop_front();
        chk("gnt", 16'(gnt), 16'(me.g));
      end else chk("gnt_idle", 16'(gnt), 16'h0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        me = exp_q.pop_front();
        chk("rnd_valid", 16'(rnd_valid), 16'h1);
        chk("rnd", 16'(rnd), 16'(me.w));
        chk("rnd_id", 16'(rnd_id), 16'(me.id));
        last_w = me.w;
      end else begin
        chk("rnd_valid_idle", 16'(rnd_valid), 16'h0);
        chk("rnd_hold", 16'(rnd), 16'(last_w));
      end
    end
  end

  always @(negedge clk) begin
    if (rst0) begin
      last_w0 = 8'h00;
    end else begin
      chk("w0_busy", 16'(busy0), 16'h0);
      if (w0_gnt_q.size() > 0 && w0_gnt_q[0].cyc == cyc) begin
        me0 = w0_gnt_q.pop_front();
        chk("w0_gnt", 16'(gnt0), 16'(me0.g));
      end else chk("w0_gnt_idle", 16'(gnt0), 16'h0);
      if (w0_exp_q.size() > 0 && w0_exp_q[0].cyc == cyc) begin
        me0 = w0_exp_q.pop_front();
        chk("w0_rnd_valid", 16'(rnd_valid0), 16'h1);
        chk("w0_rnd", 16'(rnd0), 16'(me0.w));
        chk("w0_rnd_id", 16'(rnd_id0), 16'(me0.id));
        last_w0 = me0.w;
      end else begin
        chk("w0_rnd_valid_idle", 16'(rnd_valid0), 16'h0);
        chk("w0_rnd_hold", 16'(rnd0), 16'(last_w0));
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1 of cycle k: req is sampled at edge k+1, so an expected
  // grant shows on gnt in cycle k+1 and its word in cycle k+2.
  task automatic step(input logic [3:0] r, input int id, input int word, input logic exp_busy);
    ent_t e;
    req = r;
    if (id >= 0) begin
      e.cyc = cyc + 1; e.g = 4'b0001 << id; e.id = 2'(id); e.w = 8'h00;
      gnt_q.push_back(e);
      e.cyc = cyc + 2; e.w = (word >= 0) ? 8'(word) : pcg_word(m_state);
      exp_q.push_back(e);
      m_state = pcg_step(m_state);
    end
    @(negedge clk);
    chk("busy", 16'(busy), 16'(exp_busy));
    @(posedge clk); #1;
  endtask

  task automatic warm(input logic [3:0] r, input logic exp_busy);
    step(r, -1, -1, exp_busy);
    m_state = pcg_step(m_state);
  endtask

  task automatic load(input logic [15:0] s, input logic [3:0] r, input logic exp_busy);
    seed_load = 1'b1; seed = s; m_state = s;
    step(r, -1, -1, exp_busy);
    seed_load = 1'b0;
  endtask

  task automatic step0(input logic [3:0] r, input int id, input int word, input logic ld);
    ent_t e;
    req0 = r; seed_load0 = ld; seed0 = 16'h1405;
    if (id >= 0) begin
      e.cyc = cyc + 1; e.g = 4'b0001 << id; e.id = 2'(id); e.w = 8'h00;
      w0_gnt_q.push_back(e);
      e.cyc = cyc + 2; e.w = 8'(word);
      w0_exp_q.push_back(e);
    end
    @(posedge clk); #1;
    seed_load0 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rst0 = 1'b0; seed_load = 1'b0; seed_load0 = 1'b0;
    seed = 16'h0; seed0 = 16'h0; req = 4'h0; req0 = 4'h0; m_state = 16'h0;
    #1 rst = 1'b1; rst0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", 16'(gnt), 16'h0);
    chk("reset_rnd", 16'(rnd), 16'h0);
    chk("reset_rnd_id", 16'(rnd_id), 16'h0);
    chk("reset_rnd_valid", 16'(rnd_valid), 16'h0);
    chk("reset_busy", 16'(busy), 16'h1);
    chk("w0_reset_busy", 16'(busy0), 16'h0);
    @(posedge clk); #1;

    // WARMUP=0: words 00, C0, 45 back to back, then reseed with a word in flight
    rst0 = 1'b0;
    step0(4'b0001, 0, 'h00, 1'b0);
    step0(4'b0001, 0, 'hC0, 1'b0);
    step0(4'b0001, 0, 'h45, 1'b0);
    step0(4'b0001, -1, -1, 1'b1);
    step0(4'b0001, 0, 'hC0, 1'b0);
    step0(4'b0001, 0, 'h45, 1'b0);
    repeat (3) step0(4'b0000, -1, -1, 1'b0);
    rst0 = 1'b1;

    // WARMUP=2: two warm cycles, first word 0x45
    req = 4'b0001; rst = 1'b0; m_state = 16'h0000;
    warm(4'b0001, 1'b1);
    warm(4'b0001, 1'b1);
    step(4'b0001, 0, 'h45, 1'b0);
    step(4'b0001, 0, -1, 1'b0);
    step(4'b0001, 0, -1, 1'b0);
    // all four active: round robin from requester 1
    step(4'b1111, 1, -1, 1'b0);
    step(4'b1111, 2, -1, 1'b0);
    step(4'b1111, 3, -1, 1'b0);
    step(4'b1111, 0, -1, 1'b0);
    step(4'b1111, 1, -1, 1'b0);
    // ptr=1 with req=1010
    step(4'b1010, 3, -1, 1'b0);
    step(4'b1010, 1, -1, 1'b0);
    step(4'b1010, 3, -1, 1'b0);
    // no requests: state and ptr hold
    step(4'b0000, -1, -1, 1'b0);
    step(4'b0000, -1, -1, 1'b0);
    step(4'b0100, 2, -1, 1'b0);
    step(4'b1111, 3, -1, 1'b0);
    // reseed with a grant in flight, warm-up again, ptr survives the load
    load(16'h1405, 4'b1111, 1'b0);
    warm(4'b1111, 1'b1);
    warm(4'b1111, 1'b1);
    step(4'b1111, 0, -1, 1'b0);
    step(4'b1111, 1, -1, 1'b0);
    step(4'b1111, 2, -1, 1'b0);
    step(4'b1111, 3, -1, 1'b0);

    // one-cycle reset mid-stream: in-flight words are dropped
    rst = 1'b1;
    while (gnt_q.size() > 0 && gnt_q[$].cyc >= cyc) void'(gnt_q.pop_back());
    while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
    @(negedge clk);
    chk("midrst_gnt", 16'(gnt), 16'h0);
    chk("midrst_rnd_valid", 16'(rnd_valid), 16'h0);
    chk("midrst_rnd", 16'(rnd), 16'h0);
    chk("midrst_busy", 16'(busy), 16'h1);
    @(posedge clk); #1;
    rst = 1'b0; m_state = 16'h0000;
    warm(4'b1111, 1'b1);
    warm(4'b1111, 1'b1);
    step(4'b1111, 0, 'h45, 1'b0);
    step(4'b1111, 1, -1, 1'b0);
    step(4'b1111, 2, -1, 1'b0);
    repeat (3) step(4'b0000, -1, -1, 1'b0);

    chk("gnt_q_drained", 16'(gnt_q.size()), 16'h0);
    chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
    chk("w0_gnt_q_drained", 16'(w0_gnt_q.size()), 16'h0);
    chk("w0_exp_q_drained", 16'(w0_exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pcg_share_arbiter.md
# pcg_share_arbiter

Round-robin arbiter and sequencer that shares one 16-bit PCG-style noise generator among several overlay requesters in the VGA demo datapath. Each grant advances the generator state exactly once and returns one 8-bit random word tagged with the winning requester's index, so no two consumers ever see the same word. The block also handles reseeding and a warm-up phase that discards initial outputs after reset or a seed load. It sits between the PRNG-driven overlay logic and the pixel output stage.

## Interface

- NREQ, 4, number of requesters (2..8)
- WARMUP, 2, generator steps discarded after reset or seed load (0..15)
- RESET_SEED, 16'h0000, generator state loaded by reset

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- seed_load  in  1  load `seed` into the generator state (single-cycle strobe)
- seed  in  16  new generator state
- req  in  NREQ  level request per requester
- gnt  out  NREQ  one-hot, single-cycle grant pulse, registered
- rnd  out  8  random word, registered
- rnd_id  out  $clog2(NREQ)  index of the requester that owns `rnd`
- rnd_valid  out  1  `rnd`/`rnd_id` valid this cycle
- busy  out  1  high while in WARM state

## Operation

- Generator step: state_next = state*16'h5851 + 16'h1405, computed mod 2^16.
- Output function of a state s:
  - x = (s ^ (s>>1))[10:3], 8 bits.
  - r = s[5:3].
  - word = x rotated right by r.
- FSM states:
  - WARM: state advances every cycle; a counter runs to WARMUP; no grants; busy=1. When the count reaches WARMUP (immediately if WARMUP=0), go to RUN.
  - RUN: arbitration is enabled; busy=0.
- Arbitration in RUN, on each edge where any req bit is high and seed_load=0:
  - Winner is the first set req bit scanning upward from ptr+1, wrapping modulo NREQ.
  - gnt <= onehot(winner); ptr <= winner.
  - The word of the current (pre-advance) state is captured into the output pipeline; state <= state_next.
- No req bits high: gnt=0, state holds, ptr holds.
- Requester behaviour:
  - A requester holding req high is granted again only after every other active requester has been served once.
  - req may drop at any time. A request removed before the arbitration edge is simply not considered.
- seed_load (any FSM state): state <= seed; warm-up counter cleared; FSM -> WARM; no grant that cycle. Words already in the pipeline still emerge with their original rnd_id.
- Reset values:
  - state=RESET_SEED, FSM=WARM, counter=0, ptr=NREQ-1 (first scan starts at requester 0).
  - gnt=0, rnd=0, rnd_id=0, rnd_valid=0.
  - busy=1 unless WARMUP=0, in which case busy is 0 from the first cycle after reset release.
- Reset asserted mid-operation clears everything immediately, including in-flight words. A word in flight is never delivered after reset.

## Timing

- Arbitration edge E: gnt is high in the cycle following E.
- Internal pipeline: stage 1 (x, r, id) is captured at E; stage 2 (rotate) at E+1.
- rnd/rnd_id/rnd_valid are high exactly one cycle after the matching gnt pulse.
- Throughput: one grant and one word per cycle, sustained.
- rnd_valid is a one-cycle pulse per grant. rnd holds its last value while rnd_valid=0.
- After reset or seed_load the first grant can occur at the edge WARMUP+1 cycles later. Example: WARMUP=2, seed_load sampled at edge 0 → WARM steps at edges 1 and 2 → first arbitration edge is 3.
- seed_load and an active req at the same edge: seed_load wins and no grant is issued.

## Test plan

- WARMUP=0, RESET_SEED=0, req=4'b0001 held after reset → rnd sequence 0x00, 0xC0, 0x45 on consecutive cycles, rnd_id=0. State after three grants is 0x219A stepped once more.
- Default WARMUP=2, seed 0, req=0001 → busy high for 2 cycles after reset; first rnd=0x45.
- All four req high continuously → gnt cycles 0001, 0010, 0100, 1000, 0001. rnd_id follows 0,1,2,3,0, each one cycle after its gnt.
- req=1010 with ptr=1 → next grants go to 3, then 1, then 3. Requesters 0 and 2 are never granted.
- seed_load with seed=16'h1405 while a word is in flight, WARMUP=0 → the in-flight word is still delivered. There is no gnt at the load edge. The next granted word is 0xC0.
- rst asserted for one cycle during a continuous grant stream → gnt and rnd_valid are 0 next cycle. After release, the sequence restarts from RESET_SEED and the grant order starts at requester 0.
